// File: rtl/map_bit_packer.sv
// Packs MAP decoder hard decisions LSB-first into WORD_W-bit words on a valid/ready
// stream, flagging frame ends, framing errors and counting delivered frames.
module map_bit_packer #(
    parameter int WORD_W     = 8,
    parameter int FRAME_BITS = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_bit,
    input  logic              in_sof,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              frame_err,
    output logic [15:0]       frames_done
);

    localparam int IDX_W = $clog2(WORD_W + 1);
    localparam int CNT_W = $clog2(FRAME_BITS + 1);
    localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(WORD_W);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state;
    state_t            next_state;
    logic [WORD_W-1:0] pack;
    logic [WORD_W-1:0] pack_next;
    logic [IDX_W-1:0]  bit_idx;
    logic [IDX_W-1:0]  base_idx;
    logic [IDX_W-1:0]  idx_next;
    logic [CNT_W-1:0]  frame_cnt;
    logic [CNT_W-1:0]  base_cnt;
    logic [CNT_W-1:0]  cnt_next;
    logic              accept;
    logic              restart;
    logic              append;
    logic              take;
    logic              err;
    logic              frame_end;
    logic              word_done;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (take) begin
            next_state = frame_end ? IDLE : FILL;
        end
    end

    // Any accepted SOF (re)starts a frame from an empty pack; premature SOF discards the partial word.
    always_comb begin
        restart   = accept && in_sof;
        append    = accept && !in_sof && (state == FILL);
        take      = restart || append;
        err       = accept && ((state == IDLE) ? !in_sof : in_sof);
        base_idx  = restart ? '0 : bit_idx;
        base_cnt  = restart ? '0 : frame_cnt;
        pack_next = (restart ? '0 : pack) | ({{(WORD_W-1){1'b0}}, in_bit} << base_idx);
        idx_next  = base_idx + 1'b1;
        cnt_next  = base_cnt + 1'b1;
        frame_end = take && (cnt_next == CNT_FULL);
        word_done = take && ((idx_next == IDX_FULL) || frame_end);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pack      <= '0;
            bit_idx   <= '0;
            frame_cnt <= '0;
        end else if (take) begin
            pack      <= word_done ? '0 : pack_next;
            bit_idx   <= word_done ? '0 : idx_next;
            frame_cnt <= frame_end ? '0 : cnt_next;
        end
    end

    // A completing bit can only be accepted when the output slot is free or draining this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            frame_err   <= 1'b0;
            frames_done <= '0;
        end else begin
            frame_err <= err;
            if (out_valid && out_ready && out_last) begin
                frames_done <= frames_done + 16'd1;
            end
            if (word_done) begin
                out_valid <= 1'b1;
                out_data  <= pack_next;
                out_last  <= frame_end;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_map_bit_packer.sv
// Directed and randomized bench for map_bit_packer, checked against a frame-level
// queue model; a second instance with single-bit frames exercises the frames_done wrap.
module tb_map_bit_packer;

    localparam int WW = 8;
    localparam int FB = 20;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid;
    logic          in_ready;
    logic          in_bit;
    logic          in_sof;
    logic          out_valid;
    logic          out_ready;
    logic [WW-1:0] out_data;
    logic          out_last;
    logic          frame_err;
    logic [15:0]   frames_done;

    logic          w_in_valid;
    logic          w_in_ready;
    logic          w_in_bit;
    logic          w_in_sof;
    logic          w_out_valid;
    logic          w_out_ready;
    logic [1:0]    w_out_data;
    logic          w_out_last;
    logic          w_frame_err;
    logic [15:0]   w_frames_done;

    int checks = 0;
    int errors = 0;
    int err_seen = 0;
    int err_snap;

    logic          exp_valid;
    logic [WW-1:0] exp_data;
    logic          exp_last;
    logic          err_pend;
    logic [15:0]   exp_frames;
    bit            in_frame;
    bit            cur[$];

    always #5 clk = ~clk;

    map_bit_packer #(.WORD_W(WW), .FRAME_BITS(FB)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit), .in_sof(in_sof),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .frame_err(frame_err), .frames_done(frames_done)
    );

    map_bit_packer #(.WORD_W(2), .FRAME_BITS(1)) wrap_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_bit(w_in_bit), .in_sof(w_in_sof),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data), .out_last(w_out_last),
        .frame_err(w_frame_err), .frames_done(w_frames_done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        exp_valid  = 1'b0;
        exp_data   = '0;
        exp_last   = 1'b0;
        err_pend   = 1'b0;
        exp_frames = '0;
        in_frame   = 1'b0;
        cur.delete();
    endtask

    // One clock: check registered outputs, drive inputs, check in_ready, then advance the model.
    task automatic applyStimulus(input logic v, input logic sof, input logic b, input logic ordy);
        logic          accept;
        logic          err_now;
        int            base;
        logic [WW-1:0] word;
        @(negedge clk);
        checkOutput("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) begin
            checkOutput("out_data", 32'(out_data), 32'(exp_data));
            checkOutput("out_last", 32'(out_last), 32'(exp_last));
        end
        checkOutput("frame_err", 32'(frame_err), 32'(err_pend));
        checkOutput("frames_done", 32'(frames_done), 32'(exp_frames));
        if (frame_err) err_seen++;
        in_valid  = v;
        in_sof    = sof;
        in_bit    = b;
        out_ready = ordy;
        #1;
        checkOutput("in_ready", 32'(in_ready), 32'(!exp_valid || ordy));
        accept  = v && (!exp_valid || ordy);
        err_now = 1'b0;
        if (exp_valid && ordy) begin
            if (exp_last) exp_frames = exp_frames + 16'd1;
            exp_valid = 1'b0;
        end
        if (accept) begin
            if (sof) begin
                if (in_frame) err_now = 1'b1;
                cur.delete();
                cur.push_back(b);
                in_frame = 1'b1;
            end else if (!in_frame) begin
                err_now = 1'b1;
            end else begin
                cur.push_back(b);
            end
            if (in_frame && ((cur.size() % WW == 0) || (cur.size() == FB))) begin
                base = ((cur.size() - 1) / WW) * WW;
                word = '0;
                for (int i = base; i < cur.size(); i++) word[i-base] = cur[i];
                exp_valid = 1'b1;
                exp_data  = word;
                exp_last  = (cur.size() == FB);
                if (exp_last) begin
                    in_frame = 1'b0;
                    cur.delete();
                end
            end
        end
        err_pend = err_now;
    endtask

    task automatic sendBits(input logic [31:0] bits, input int n, input logic sof_first, input logic ordy);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, sof_first && (i == 0), bits[i], ordy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_out_data"}, 32'(out_data), 32'd0);
        checkOutput({tag, "_out_last"}, 32'(out_last), 32'd0);
        checkOutput({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        checkOutput({tag, "_frames_done"}, 32'(frames_done), 32'd0);
        checkOutput({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        in_valid = 1'b0; in_sof = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
        w_in_valid = 1'b0; w_in_sof = 1'b0; w_in_bit = 1'b0; w_out_ready = 1'b1;
        modelReset();
        repeat (2) @(negedge clk);
        #1;
        checkResetOutputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        sendBits(32'h8D, 8, 1'b1, 1'b1);
        settle();
        checkOutput("pack_valid", 32'(out_valid), 32'd1);
        checkOutput("pack_8d", 32'(out_data), 32'h8D);
        checkOutput("pack_last", 32'(out_last), 32'd0);
        sendBits(32'hFFF, 12, 1'b0, 1'b1);
        idle(3);
        checkOutput("frames_a", 32'(frames_done), 32'd1);

        sendBits(32'hFFFFF, 20, 1'b1, 1'b1);
        settle();
        checkOutput("partial_data", 32'(out_data), 32'h0F);
        checkOutput("partial_last", 32'(out_last), 32'd1);
        idle(2);
        checkOutput("frames_b", 32'(frames_done), 32'd2);

        sendBits(32'h0D, 7, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
        settle();
        checkOutput("stall_data", 32'(out_data), 32'h8D);
        checkOutput("stall_valid", 32'(out_valid), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        sendBits(32'h5A5, 11, 1'b0, 1'b1);
        idle(3);
        checkOutput("frames_c", 32'(frames_done), 32'd3);

        err_snap = err_seen;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, i[0], 1'b1);
        idle(2);
        checkOutput("idle_err_pulses", 32'(err_seen - err_snap), 32'd3);
        checkOutput("idle_err_no_out", 32'(out_valid), 32'd0);

        err_snap = err_seen;
        sendBits(32'h1F, 5, 1'b1, 1'b1);
        sendBits(32'hC3A5E, 20, 1'b1, 1'b1);
        idle(3);
        checkOutput("early_sof_pulses", 32'(err_seen - err_snap), 32'd1);
        checkOutput("frames_d", 32'(frames_done), 32'd4);

        sendBits(32'hA5, 8, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        in_valid = 1'b0;
        checkResetOutputs("mid_reset");
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        for (int i = 0; i < 1500; i++) begin
            logic v;
            logic sof;
            v   = ($urandom_range(0, 3) != 0);
            sof = in_frame ? ($urandom_range(0, 60) == 0) : ($urandom_range(0, 3) != 0);
            applyStimulus(v, sof, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
        end
        idle(3);

        for (int i = 0; i < 65535; i++) begin
            @(negedge clk);
            w_in_valid = 1'b1;
            w_in_sof   = 1'b1;
            w_in_bit   = i[0];
        end
        @(negedge clk);
        w_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("wrap_ffff", 32'(w_frames_done), 32'hFFFF);
        w_in_valid = 1'b1;
        w_in_bit   = 1'b1;
        @(negedge clk);
        w_in_valid = 1'b0;
        checkOutput("wrap_word", 32'(w_out_data), 32'h1);
        checkOutput("wrap_last", 32'(w_out_last), 32'd1);
        @(negedge clk);
        checkOutput("wrap_zero", 32'(w_frames_done), 32'd0);
        checkOutput("wrap_drained", 32'(w_out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
